// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Sequencer that time-shares one external 4-bit full adder to add two
// WIDTH-bit operands one nibble per clock, least significant nibble first.
// Operands are captured on an accepted start. The running carry is kept in a
// register between steps. The result is assembled nibble by nibble.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   When defined, a 'sub' input is added and latched with the operands.
//   With sub=1, the B nibbles are inverted and the first carry-in is forced
//   to 1, so result = op_a - op_b and carry_out=1 means "no borrow".
//
// WIDTH must be a multiple of 4 and at least 8.

`timescale 1ns/1ps

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic [3:0]       adder_a,
    output logic [3:0]       adder_b,
    output logic             adder_cin,
    input  logic [3:0]       adder_sum,
    input  logic             adder_cout
);

    // Number of nibble steps and the width of the step counter.
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] LAST_STEP = KW'(NIB - 1);

    // Sequencer states.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [KW-1:0]    step;
    logic [KW+1:0]    bit_base;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             cin_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg;
    logic             accept;
    logic             last_step;
    logic [3:0]       b_nib;
    logic             first_cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_reg;
`endif

    // A start is honoured in IDLE and also in DONE, which allows one
    // operation to follow another without an idle gap. It is ignored in RUN.
    assign accept    = start && (state != RUN);
    assign last_step = (step == LAST_STEP);

    // Bit offset of the nibble being processed in the current step.
    assign bit_base  = {step, 2'b00};

    // The status outputs are plain decodes of the state register.
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;

    // B nibble and first-step carry. In subtract mode, B is inverted and
    // the +1 of the two's complement enters through the first carry-in.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_nib     = sub_reg ? ~b_reg[bit_base +: 4] : b_reg[bit_base +: 4];
    assign first_cin = sub_reg ? 1'b1 : cin_reg;
`else
    assign b_nib     = b_reg[bit_base +: 4];
    assign first_cin = cin_reg;
`endif

    // Adder inputs are driven only while running. They are held at zero
    // otherwise, so a time-sharing integrator sees a quiet bus.
    always_comb begin
        adder_a   = 4'd0;
        adder_b   = 4'd0;
        adder_cin = 1'b0;
        if (state == RUN) begin
            adder_a   = a_reg[bit_base +: 4];
            adder_b   = b_nib;
            adder_cin = (step == '0) ? first_cin : carry_reg;
        end
    end

    // State transitions: IDLE -> RUN on start, RUN -> DONE after the last
    // nibble, and DONE -> RUN (back-to-back) or DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (last_step) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Step counter: cleared on an accepted start and advanced once per
    // nibble while running. It wraps to zero after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
        end else if (accept) begin
            step <= '0;
        end else if (state == RUN) begin
            if (last_step) begin
                step <= '0;
            end else begin
                step <= step + 1'b1;
            end
        end
    end

    // Operand capture: operands stay frozen for the whole run, so a start
    // that is ignored during RUN cannot disturb the sum in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            cin_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            cin_reg <= carry_in;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    // The subtract request is captured together with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_reg <= 1'b0;
        end else if (accept) begin
            sub_reg <= sub;
        end
    end
`endif

    // Carry chain between nibbles: each step's carry-out feeds the next
    // step's carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
        end else if (accept) begin
            carry_reg <= 1'b0;
        end else if (state == RUN) begin
            carry_reg <= adder_cout;
        end
    end

    // Result assembly: each step writes its nibble in place, so the upper
    // nibbles still hold stale data until the run reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= '0;
        end else if (state == RUN) begin
            result_reg[bit_base +: 4] <= adder_sum;
        end
    end

    // Final carry: taken only from the last nibble and then held with the
    // result until the next run completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_out_reg <= 1'b0;
        end else if ((state == RUN) && last_step) begin
            carry_out_reg <= adder_cout;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16), including
// the SERIAL_ADDER_SUB_EN subtract mode when that macro is defined.
// The shared 4-bit adder is modelled here. Expected sums are queued when
// a start is driven and are compared when done pulses.

`timescale 1ns/1ps

module tb_nibble_serial_adder_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_in;
    logic             sub_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic [3:0]       adder_a;
    logic [3:0]       adder_b;
    logic             adder_cin;
    logic [3:0]       adder_sum;
    logic             adder_cout;

    logic [WIDTH:0]   sb[$];
    int               checks = 0;
    int               errors = 0;

    // 10 ns clock.
    always #5 clk = ~clk;

    // Behavioural stand-in for the external 4-bit full adder.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_cin};

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .carry_in   (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub        (sub_in),
`endif
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout)
    );

    // Drives a one-cycle start and queues the expected {carry, result}.
    // With now=1, the start is raised immediately instead of at the next
    // falling edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input logic s, input bit now);
        logic [WIDTH:0] e;
        if (!now) @(negedge clk);
        op_a     = a;
        op_b     = b;
        carry_in = c;
        sub_in   = s;
        start    = 1'b1;
        if (s) e = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else   e = {1'b0, a} + {1'b0, b} + {16'd0, c};
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts falling edges from the start edge until done (bounded).
    task automatic wait_done(output int lat, output int busy_cycles, output bit seen);
        lat = 0;
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        start    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        carry_in = 1'b0;
        sub_in   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++;
        if (result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_result got %h want 0000", result); end
        checks++;
        if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry got %b want 0", carry_out); end
        checks++;
        if ({adder_a, adder_b, adder_cin} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_adder_bus got %h/%h/%b want 0/0/0", adder_a, adder_b, adder_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, bc;
        bit seen;
        logic [WIDTH:0] e;
        start_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        wait_done(lat, bc, seen);
        checks++;
        if (!seen || lat != 5) begin errors++; $display("[TB] FAIL basic_latency got %0d want 5", lat); end
        checks++;
        if (bc != 4) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 4", bc); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL basic_scoreboard got empty want entry"); end
        else begin
            e = sb.pop_front();
            if ({carry_out, result} !== e) begin
                errors++;
                $display("[TB] FAIL basic_result got %h want %h", {carry_out, result}, e);
            end
        end
    endtask

    task automatic test_ripple;
        logic exp_cin;
        logic [WIDTH:0] e;
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_cin = (k == 0) ? 1'b0 : 1'b1;
            checks++;
            if (adder_cin !== exp_cin) begin
                errors++;
                $display("[TB] FAIL ripple_cin_step%0d got %b want %b", k, adder_cin, exp_cin);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL ripple_done got %b want 1", done); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL ripple_scoreboard got empty want entry"); end
        else begin
            e = sb.pop_front();
            if ({carry_out, result} !== e) begin
                errors++;
                $display("[TB] FAIL ripple_result got %h want %h", {carry_out, result}, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        bit seen;
        logic [WIDTH:0] e;
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        wait_done(lat, bc, seen);
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL b2b_first_done got 0 want 1"); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL b2b_first_scoreboard got empty want entry"); end
        else begin
            e = sb.pop_front();
            if ({carry_out, result} !== e) begin
                errors++;
                $display("[TB] FAIL b2b_first_result got %h want %h", {carry_out, result}, e);
            end
        end
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        wait_done(lat, bc, seen);
        checks++;
        if (!seen || lat != 5) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 5", lat); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL b2b_second_scoreboard got empty want entry"); end
        else begin
            e = sb.pop_front();
            if ({carry_out, result} !== e) begin
                errors++;
                $display("[TB] FAIL b2b_second_result got %h want %h", {carry_out, result}, e);
            end
        end
    endtask

    task automatic test_ignore_start;
        int dcount;
        logic [WIDTH:0] got, e;
        dcount = 0;
        got = '0;
        start_op(16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        op_a     = 16'hAAAA;
        op_b     = 16'h5555;
        carry_in = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                dcount++;
                if (dcount == 1) got = {carry_out, result};
            end
        end
        checks++;
        if (dcount != 1) begin errors++; $display("[TB] FAIL ignore_done_count got %0d want 1", dcount); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL ignore_scoreboard got empty want entry"); end
        else begin
            e = sb.pop_front();
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL ignore_result got %h want %h", got, e);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, dseen;
        bit seen;
        logic [WIDTH:0] e;
        dseen = 0;
        start_op(16'h4321, 16'h1234, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (sb.size() > 0) e = sb.pop_back();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        checks++;
        if (result !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_result got %h want 0000", result); end
        checks++;
        if ({adder_a, adder_b, adder_cin} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL midrst_adder_bus got %h/%h/%b want 0/0/0", adder_a, adder_b, adder_cin);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dseen++;
        end
        checks++;
        if (dseen != 0) begin errors++; $display("[TB] FAIL midrst_no_done got %0d want 0", dseen); end
        start_op(16'h4321, 16'h1234, 1'b0, 1'b0, 1'b0);
        wait_done(lat, bc, seen);
        checks++;
        if (!seen || lat != 5) begin errors++; $display("[TB] FAIL midrst_restart_latency got %0d want 5", lat); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("[TB] FAIL midrst_scoreboard got empty want entry"); end
        else begin
            e = sb.pop_front();
            if ({carry_out, result} !== e) begin
                errors++;
                $display("[TB] FAIL midrst_restart_result got %h want %h", {carry_out, result}, e);
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat, bc;
        bit seen;
        logic [WIDTH:0] e;
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        wait_done(lat, bc, seen);
        checks++;
        if (sb.size() == 0 || !seen) begin errors++; $display("[TB] FAIL sub_neg_done got %b want 1", seen); end
        else begin
            e = sb.pop_front();
            if ({carry_out, result} !== e) begin
                errors++;
                $display("[TB] FAIL sub_neg_result got %h want %h", {carry_out, result}, e);
            end
        end
        start_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
        wait_done(lat, bc, seen);
        checks++;
        if (sb.size() == 0 || !seen) begin errors++; $display("[TB] FAIL sub_pos_done got %b want 1", seen); end
        else begin
            e = sb.pop_front();
            if ({carry_out, result} !== e) begin
                errors++;
                $display("[TB] FAIL sub_pos_result got %h want %h", {carry_out, result}, e);
            end
        end
        sub_in = 1'b0;
    endtask
`endif

    // Runs each scenario in sequence and prints the summary line.
    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Stops the run if the sequence above never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
